// File: rtl/reg_hazard_scoreboard.sv
// reg_hazard_scoreboard: per-register in-flight write tracking,
// decode issue/stall decision, stall watchdog and stall counter.
module reg_hazard_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int RADDR_W    = 5,
  parameter int WB_LATENCY = 3,
  parameter int MAX_STALL  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  input  logic [RADDR_W-1:0] issue_rs,
  input  logic [RADDR_W-1:0] issue_rt,
  input  logic               issue_uses_rs,
  input  logic               issue_uses_rt,
  input  logic               issue_writes,
  input  logic [RADDR_W-1:0] issue_rd,
  input  logic               flush,
  output logic               pending_rs,
  output logic               pending_rt,
  output logic               stall,
  output logic               issue_accept,
  output logic               stall_timeout,
  output logic [15:0]        stall_total
);

  localparam int CW = $clog2(WB_LATENCY + 1);
  localparam logic [CW-1:0] LOAD = CW'(WB_LATENCY);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [7:0]    MAXS = 8'(MAX_STALL);

  logic [CW-1:0] cnt_q [NUM_REGS];
  logic [CW-1:0] cnt_d [NUM_REGS];

  logic [7:0]  consec_q, consec_d;
  logic        timeout_q, timeout_d;
  logic [15:0] total_q, total_d;

  logic hazard;
  logic load;

  // Hazard check uses the counters before this edge's load,
  // so an instruction reading its own destination never self-stalls.
  assign pending_rs = issue_uses_rs && (issue_rs != '0)
                      && (cnt_q[issue_rs] != '0);
  assign pending_rt = issue_uses_rt && (issue_rt != '0)
                      && (cnt_q[issue_rt] != '0);

  assign hazard       = pending_rs || pending_rt;
  assign stall        = issue_valid && hazard && !flush;
  assign issue_accept = issue_valid && !hazard && !flush;

  assign load = issue_accept && issue_writes && (issue_rd != '0);

  // Next counters: age every entry, then new write load, then flush.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - ONE : '0;
    end
    if (load) begin
      cnt_d[issue_rd] = LOAD;
    end
    if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_d[r] = '0;
      end
    end
    cnt_d[0] = '0;
  end

  // Counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Watchdog and performance counter next state.
  always_comb begin
    consec_d  = '0;
    timeout_d = timeout_q;
    total_d   = total_q;
    if (stall) begin
      consec_d = (consec_q >= MAXS) ? MAXS : consec_q + 8'd1;
      if (total_q != 16'hFFFF) begin
        total_d = total_q + 16'd1;
      end
    end
    if (consec_d == MAXS) begin
      timeout_d = 1'b1;
    end
  end

  // Watchdog and performance counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      consec_q  <= '0;
      timeout_q <= 1'b0;
      total_q   <= '0;
    end else begin
      consec_q  <= consec_d;
      timeout_q <= timeout_d;
      total_q   <= total_d;
    end
  end

  assign stall_timeout = timeout_q;
  assign stall_total   = total_q;

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// tb_reg_hazard_scoreboard: directed scenarios plus random traffic
// against a ready-time reference model, on two parameter sets.
module tb_reg_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [4:0] issue_rs;
  logic [4:0] issue_rt;
  logic       issue_uses_rs;
  logic       issue_uses_rt;
  logic       issue_writes;
  logic [4:0] issue_rd;
  logic       flush;

  logic        prs_a, prt_a, stall_a, acc_a, to_a;
  logic [15:0] tot_a;
  logic        prs_b, prt_b, stall_b, acc_b, to_b;
  logic [15:0] tot_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_hazard_scoreboard #(
    .NUM_REGS(32), .RADDR_W(5), .WB_LATENCY(3), .MAX_STALL(15)
  ) u_a (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_uses_rs(issue_uses_rs), .issue_uses_rt(issue_uses_rt),
    .issue_writes(issue_writes), .issue_rd(issue_rd),
    .flush(flush),
    .pending_rs(prs_a), .pending_rt(prt_a),
    .stall(stall_a), .issue_accept(acc_a),
    .stall_timeout(to_a), .stall_total(tot_a)
  );

  reg_hazard_scoreboard #(
    .NUM_REGS(32), .RADDR_W(5), .WB_LATENCY(5), .MAX_STALL(4)
  ) u_b (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_uses_rs(issue_uses_rs), .issue_uses_rt(issue_uses_rt),
    .issue_writes(issue_writes), .issue_rd(issue_rd),
    .flush(flush),
    .pending_rs(prs_b), .pending_rt(prt_b),
    .stall(stall_b), .issue_accept(acc_b),
    .stall_timeout(to_b), .stall_total(tot_b)
  );

  // Reference model: each register records the cycle index at which
  // its pending write becomes readable.
  longint now = 0;
  longint rdy [2][32];
  int     consec [2];
  bit     tmo [2];
  int     tot [2];
  bit     e_prs [2], e_prt [2], e_stall [2], e_acc [2];

  function automatic int lat_of(int k);
    return (k == 0) ? 3 : 5;
  endfunction

  function automatic int ms_of(int k);
    return (k == 0) ? 15 : 4;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) rdy[k][r] = 0;
      consec[k] = 0;
      tmo[k]    = 1'b0;
      tot[k]    = 0;
    end
  endtask

  task automatic predict();
    for (int k = 0; k < 2; k++) begin
      bit hz;
      e_prs[k] = issue_uses_rs && issue_rs != 0
                 && now < rdy[k][issue_rs];
      e_prt[k] = issue_uses_rt && issue_rt != 0
                 && now < rdy[k][issue_rt];
      hz = e_prs[k] || e_prt[k];
      e_stall[k] = issue_valid && hz && !flush;
      e_acc[k]   = issue_valid && !hz && !flush;
    end
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (flush) begin
        for (int r = 0; r < 32; r++) rdy[k][r] = 0;
      end else if (e_acc[k] && issue_writes && issue_rd != 0) begin
        rdy[k][issue_rd] = now + 1 + lat_of(k);
      end
      if (e_stall[k]) begin
        consec[k] = (consec[k] + 1 > ms_of(k)) ? ms_of(k) : consec[k] + 1;
        if (consec[k] == ms_of(k)) tmo[k] = 1'b1;
        if (tot[k] < 65535) tot[k]++;
      end else begin
        consec[k] = 0;
      end
    end
    now++;
    #1;
  endtask

  task automatic idle();
    issue_valid   = 1'b0;
    issue_rs      = '0;
    issue_rt      = '0;
    issue_uses_rs = 1'b0;
    issue_uses_rt = 1'b0;
    issue_writes  = 1'b0;
    issue_rd      = '0;
    flush         = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (7) tick();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic drive(bit v, bit urs, logic [4:0] rs, bit wr,
                       logic [4:0] rd);
    idle();
    issue_valid   = v;
    issue_uses_rs = urs;
    issue_rs      = rs;
    issue_writes  = wr;
    issue_rd      = rd;
    #1;
  endtask

  task automatic test_reset();
    idle();
    issue_valid = 1'b1;
    rst = 1'b1;
    #2;
    n_tests++;
    if (stall_a !== 1'b0 || acc_a !== 1'b1 || prs_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_comb stall=%b acc=%b prs=%b exp 0 1 0",
               stall_a, acc_a, prs_a);
    end
    n_tests++;
    if (to_a !== 1'b0 || tot_a !== 16'd0 || to_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs to_a=%b tot_a=%0d to_b=%b exp 0 0 0",
               to_a, tot_a, to_b);
    end
    rst = 1'b0;
    model_reset();
    idle();
    tick();
  endtask

  task automatic test_independent();
    for (int i = 1; i <= 3; i++) begin
      idle();
      issue_valid   = 1'b1;
      issue_uses_rs = 1'b1;
      issue_uses_rt = 1'b1;
      issue_rs      = 5'd5;
      issue_rt      = 5'd6;
      issue_writes  = 1'b1;
      issue_rd      = 5'(i);
      #1;
      n_tests++;
      if (stall_a !== 1'b0 || acc_a !== 1'b1) begin
        n_fail++;
        $display("FAIL indep_%0d stall=%b acc=%b exp 0 1", i, stall_a, acc_a);
      end
      tick();
    end
    idle();
    #1;
    n_tests++;
    if (tot_a !== 16'd0 || tot_b !== 16'd0) begin
      n_fail++;
      $display("FAIL indep_total a=%0d b=%0d exp 0 0", tot_a, tot_b);
    end
    drain();
  endtask

  task automatic test_dependent();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 5'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'd3, 1'b1, 5'd4);
      n_tests++;
      if (stall_a !== 1'b1 || prs_a !== 1'b1 || acc_a !== 1'b0) begin
        n_fail++;
        $display("FAIL dep_stall_%0d stall=%b prs=%b acc=%b exp 1 1 0",
                 i, stall_a, prs_a, acc_a);
      end
      tick();
    end
    drive(1'b1, 1'b1, 5'd3, 1'b1, 5'd4);
    n_tests++;
    if (stall_a !== 1'b0 || acc_a !== 1'b1 || stall_b !== 1'b1) begin
      n_fail++;
      $display("FAIL dep_issue stall_a=%b acc_a=%b stall_b=%b exp 0 1 1",
               stall_a, acc_a, stall_b);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (tot_a !== 16'd3) begin
      n_fail++;
      $display("FAIL dep_total got=%0d exp 3", tot_a);
    end
    drain();
  endtask

  task automatic test_r0();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd0, 1'b1, 5'd2);
    n_tests++;
    if (stall_a !== 1'b0 || acc_a !== 1'b1 || prs_a !== 1'b0
        || stall_b !== 1'b0) begin
      n_fail++;
      $display("FAIL r0 stall_a=%b acc_a=%b prs_a=%b stall_b=%b exp 0 1 0 0",
               stall_a, acc_a, prs_a, stall_b);
    end
    tick();
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 5'd7);
    tick();
    drive(1'b1, 1'b1, 5'd7, 1'b0, 5'd0);
    n_tests++;
    if (stall_a !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre stall=%b exp 1", stall_a);
    end
    tick();
    flush = 1'b1;
    #1;
    n_tests++;
    if (stall_a !== 1'b0 || acc_a !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_hold stall=%b acc=%b exp 0 0", stall_a, acc_a);
    end
    tick();
    flush = 1'b0;
    #1;
    n_tests++;
    if (stall_a !== 1'b0 || acc_a !== 1'b1 || prs_a !== 1'b0
        || stall_b !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after stall_a=%b acc_a=%b prs_a=%b stall_b=%b",
               stall_a, acc_a, prs_a, stall_b);
    end
    tick();
    drain();
  endtask

  task automatic test_watchdog();
    do_reset();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 5'd9);
    tick();
    for (int i = 0; i <= 4; i++) begin
      drive(1'b1, 1'b1, 5'd9, 1'b1, 5'd9);
      n_tests++;
      if (to_b !== (i >= 4) || stall_b !== 1'b1) begin
        n_fail++;
        $display("FAIL wdog_%0d to_b=%b stall_b=%b exp %b 1",
                 i, to_b, stall_b, (i >= 4));
      end
      tick();
    end
    drain();
    n_tests++;
    if (to_b !== 1'b1 || to_a !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_sticky to_b=%b to_a=%b exp 1 0", to_b, to_a);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 5'd5);
    tick();
    drive(1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
    tick();
    n_tests++;
    if (stall_a !== 1'b1 || tot_a !== 16'd1 || to_b !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_pre stall=%b tot=%0d to_b=%b exp 1 1 0",
               stall_a, tot_a, to_b);
    end
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (prs_a !== 1'b0 || stall_a !== 1'b0 || tot_a !== 16'd0
        || acc_a !== 1'b1) begin
      n_fail++;
      $display("FAIL arst prs=%b stall=%b tot=%0d acc=%b exp 0 0 0 1",
               prs_a, stall_a, tot_a, acc_a);
    end
    issue_valid = 1'b0;
    #1;
    n_tests++;
    if (acc_a !== 1'b0 || acc_b !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_acc a=%b b=%b exp 0 0", acc_a, acc_b);
    end
    rst = 1'b0;
    model_reset();
    tick();
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      idle();
      issue_valid   = ($urandom_range(99, 0) < 85);
      issue_uses_rs = $urandom_range(1, 0);
      issue_uses_rt = $urandom_range(1, 0);
      issue_writes  = ($urandom_range(3, 0) != 0);
      issue_rs      = 5'($urandom_range(7, 0));
      issue_rt      = 5'($urandom_range(7, 0));
      issue_rd      = 5'($urandom_range(7, 0));
      flush         = ($urandom_range(19, 0) == 0);
      #1;
      predict();
      for (int k = 0; k < 2; k++) begin
        logic        a_prs, a_prt, a_st, a_acc, a_to;
        logic [15:0] a_tot;
        a_prs = (k == 0) ? prs_a   : prs_b;
        a_prt = (k == 0) ? prt_a   : prt_b;
        a_st  = (k == 0) ? stall_a : stall_b;
        a_acc = (k == 0) ? acc_a   : acc_b;
        a_to  = (k == 0) ? to_a    : to_b;
        a_tot = (k == 0) ? tot_a   : tot_b;
        n_tests++;
        if (a_prs !== e_prs[k] || a_prt !== e_prt[k]) begin
          n_fail++;
          $display("FAIL rnd_pend k=%0d c=%0d got=%b%b exp=%b%b",
                   k, c, a_prs, a_prt, e_prs[k], e_prt[k]);
        end
        n_tests++;
        if (a_st !== e_stall[k] || a_acc !== e_acc[k]) begin
          n_fail++;
          $display("FAIL rnd_issue k=%0d c=%0d got=%b%b exp=%b%b",
                   k, c, a_st, a_acc, e_stall[k], e_acc[k]);
        end
        n_tests++;
        if (a_to !== tmo[k] || a_tot !== 16'(tot[k])) begin
          n_fail++;
          $display("FAIL rnd_regs k=%0d c=%0d got=%b/%0d exp=%b/%0d",
                   k, c, a_to, a_tot, tmo[k], tot[k]);
        end
      end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL time_limit simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    test_reset();
    test_independent();
    test_dependent();
    test_r0();
    test_flush();
    test_watchdog();
    test_async_reset();
    do_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
